// File: rtl/option_queue.sv
// Circular option FIFO between the board parser and the line solver.
// Ports: clk/rst/flush, load_*, start, pop, put_back*, option*, count/full/empty, mode, overflow/underflow.
module option_queue #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       start,
  input  logic                       pop,
  input  logic                       put_back,
  input  logic [WIDTH-1:0]           put_back_data,
  output logic [WIDTH-1:0]           option,
  output logic                       option_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [1:0]                 mode,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    RUNNING = 2'd2
  } mode_t;

  mode_t            r_mode, w_mode_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head, r_tail;
  logic [AW-1:0]    w_head_nxt;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_option;
  logic             r_valid;
  logic             r_ovf, r_udf;

  logic             w_run;
  logic             w_wr_req;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_pop_acc;
  logic             w_wr_acc;

  assign w_run     = (r_mode == RUNNING);
  assign w_wr_req  = w_run ? put_back : load_valid;
  assign w_wr_data = w_run ? put_back_data : load_data;
  assign w_pop_acc = pop && r_valid && w_run;
  assign w_wr_acc  = w_wr_req &&
                     ((r_count < CW'(DEPTH)) || w_pop_acc);
  // Stored word following the current head.
  assign w_head_nxt = r_head + AW'(1);

  always_comb begin
    w_mode_nxt = r_mode;
    unique case (r_mode)
      IDLE: begin
        if (start)           w_mode_nxt = RUNNING;
        else if (load_valid) w_mode_nxt = LOADING;
      end
      LOADING: begin
        if (start) w_mode_nxt = RUNNING;
      end
      RUNNING: w_mode_nxt = RUNNING;
      default: w_mode_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_mode <= IDLE;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_option <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_acc) r_tail <= r_tail + AW'(1);
      if (w_pop_acc) r_head <= w_head_nxt;
      r_count <= r_count + CW'(w_wr_acc) - CW'(w_pop_acc);
      if (w_pop_acc) begin
        if (r_count > CW'(1)) begin
          r_option <= r_mem[w_head_nxt];
        end else if (w_wr_acc) begin
          // Last word leaves as a new one arrives: bypass storage.
          r_option <= w_wr_data;
        end else begin
          r_valid <= 1'b0;
        end
      end else if (w_wr_acc && r_count == '0) begin
        r_option <= w_wr_data;
        r_valid  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (!flush) begin
      if (w_wr_req && !w_wr_acc) r_ovf <= 1'b1;
      if (pop && w_run && !r_valid) r_udf <= 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr_acc) r_mem[r_tail] <= w_wr_data;
  end

  assign option       = r_option;
  assign option_valid = r_valid;
  assign count        = r_count;
  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign mode         = r_mode;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
endmodule

// File: tb/tb_option_queue.sv
// Directed bench for option_queue at DEPTH=8.
// Covers load/start, pop streams, bypass, full/wrap, underflow, flush.
module tb_option_queue;
  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst, flush, load_valid, start, pop, put_back;
  logic [WIDTH-1:0] load_data, put_back_data;
  logic [WIDTH-1:0] option;
  logic             option_valid, full, empty, overflow, underflow;
  logic [3:0]       count;
  logic [1:0]       mode;

  int n_chk = 0;
  int n_err = 0;
  logic [WIDTH-1:0] q[$];

  option_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .load_valid(load_valid), .load_data(load_data),
    .start(start), .pop(pop),
    .put_back(put_back), .put_back_data(put_back_data),
    .option(option), .option_valid(option_valid),
    .count(count), .full(full), .empty(empty),
    .mode(mode), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 0; flush = 0; load_valid = 0; start = 0;
    pop = 0; put_back = 0; load_data = '0; put_back_data = '0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    #1;
    step();
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_mode", mode, 0);
    chk("rst_valid", option_valid, 0);
    chk("rst_option", option, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);

    // Load three words then start.
    load_valid = 1; load_data = 16'h0005; step();
    chk("t1_opt", option, 16'h0005);
    chk("t1_valid", option_valid, 1);
    chk("t1_mode_load", mode, 1);
    load_data = 16'h00A3; step();
    load_data = 16'h0105; step();
    load_valid = 0; start = 1; step();
    start = 0;
    chk("t1_mode_run", mode, 2);
    chk("t1_count", count, 3);
    chk("t1_head", option, 16'h0005);

    // Pop stream.
    pop = 1; step();
    chk("t2_opt1", option, 16'h00A3);
    chk("t2_cnt1", count, 2);
    step();
    chk("t2_opt2", option, 16'h0105);
    chk("t2_cnt2", count, 1);
    step();
    pop = 0;
    chk("t2_valid0", option_valid, 0);
    chk("t2_cnt0", count, 0);
    chk("t2_empty", empty, 1);
    chk("t2_udf", underflow, 0);

    // Pop while empty in RUNNING.
    pop = 1; step(); pop = 0;
    chk("t5_udf", underflow, 1);
    chk("t5_cnt", count, 0);

    // Put back into empty queue, then pop+put_back bypass.
    put_back = 1; put_back_data = 16'h00A3; step();
    put_back = 0;
    chk("t3_opt", option, 16'h00A3);
    chk("t3_cnt", count, 1);
    pop = 1; put_back = 1; put_back_data = 16'h00A3; step();
    chk("t3_byp_opt", option, 16'h00A3);
    chk("t3_byp_valid", option_valid, 1);
    chk("t3_byp_cnt", count, 1);
    put_back_data = 16'h0077; step();
    put_back = 0;
    chk("t3_byp2_opt", option, 16'h0077);
    chk("t3_byp2_cnt", count, 1);
    step(); pop = 0;
    chk("t3_drain_valid", option_valid, 0);
    chk("t3_drain_opt", option, 16'h0077);
    chk("t3_drain_cnt", count, 0);

    // load_valid ignored in RUNNING.
    load_valid = 1; load_data = 16'h0999; step(); load_valid = 0;
    chk("run_load_ign", count, 0);

    // Flush keeps the sticky flags.
    flush = 1; step(); flush = 0;
    chk("t5_fl_mode", mode, 0);
    chk("t5_fl_cnt", count, 0);
    chk("t5_fl_udf", underflow, 1);
    chk("t5_fl_opt", option, 0);

    // Fill past capacity.
    for (int i = 0; i < 9; i++) begin
      load_valid = 1; load_data = 16'h0010 + 16'(i); step();
      if (i < 8) q.push_back(16'h0010 + 16'(i));
      if (i == 7) begin
        chk("t4_full", full, 1);
        chk("t4_ovf_pre", overflow, 0);
      end
    end
    load_valid = 0;
    chk("t4_cnt", count, 8);
    chk("t4_ovf", overflow, 1);
    start = 1; step(); start = 0;

    // Pop and put back across the wrap.
    for (int i = 0; i < 8; i++) begin
      chk("t4_pb_opt", option, 32'(q[0]));
      void'(q.pop_front());
      q.push_back(16'h0100 + 16'(i));
      pop = 1; put_back = 1; put_back_data = 16'h0100 + 16'(i);
      step();
      chk("t4_pb_cnt", count, 8);
    end
    put_back = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_opt", option, 32'(q[0]));
      void'(q.pop_front());
      step();
    end
    pop = 0;
    chk("t4_end_cnt", count, 0);
    chk("t4_end_valid", option_valid, 0);

    // Flush wins over a same-cycle load.
    flush = 1; load_valid = 1; load_data = 16'h0ABC; step();
    flush = 0; load_valid = 0;
    chk("t6_mode", mode, 0);
    chk("t6_cnt", count, 0);
    chk("t6_valid", option_valid, 0);
    step();
    chk("t6_cnt2", count, 0);

    rst = 1; step(); rst = 0;
    chk("rst2_udf", underflow, 0);
    chk("rst2_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
